mc_controller: RTL

Multicycle control unit for the MIPS core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback, driving a shared-memory multicycle datapath built from the existing flop, mux, adder, register-file, sign-extend and ALU blocks. It sits directly upstream of that datapath. It consumes the opcode and funct fields from the instruction register plus the ALU zero flag. It produces every enable and mux select the datapath needs, one micro-step per clock.

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/mc_aludec.sv | 40 ++++
 rtl/mc_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// ----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode and funct field values, the aluop type and the ALU control codes.
// ----------------------------------------------------------------------------
package mc_pkg;

    // Controller states. The encodings are visible on the debug state port,
    // so they are fixed. Codes 12-15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMPEX  = 4'd11
    } state_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Coarse ALU operation requested by the FSM
    typedef logic [1:0] aluop_t;
    localparam aluop_t ALUOP_ADD   = 2'b00;
    localparam aluop_t ALUOP_SUB   = 2'b01;
    localparam aluop_t ALUOP_FUNCT = 2'b10;
    localparam aluop_t ALUOP_RSVD  = 2'b11;

    // ALU control codes
    localparam logic [2:0] ALUC_AND   = 3'b000;
    localparam logic [2:0] ALUC_OR    = 3'b001;
    localparam logic [2:0] ALUC_ADD   = 3'b010;
    localparam logic [2:0] ALUC_UNDEF = 3'b011;  // ALU yields 0
    localparam logic [2:0] ALUC_SUB   = 3'b110;
    localparam logic [2:0] ALUC_SLT   = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ----------------------------------------------------------------------------
// mc_aludec
// Combinational ALU decoder: maps the FSM's aluop and the instruction funct
// field onto the 3-bit ALU control code.
// Ports:
//   aluop      in  2  coarse operation from the FSM
//   funct      in  6  instr[5:0], only consulted when aluop selects funct
//   alucontrol out 3  ALU operation code
// ----------------------------------------------------------------------------
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD:  alucontrol = ALUC_ADD;
            ALUOP_SUB:  alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALUC_ADD;
                    FN_SUB:  alucontrol = ALUC_SUB;
                    FN_AND:  alucontrol = ALUC_AND;
                    FN_OR:   alucontrol = ALUC_OR;
                    FN_SLT:  alucontrol = ALUC_SLT;
                    // Unknown funct still completes as an R-type; the ALU
                    // produces 0 for this code and that value is written back.
                    default: alucontrol = ALUC_UNDEF;
                endcase
            end
            ALUOP_RSVD: alucontrol = ALUC_ADD;
            default:    alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller
// Moore control FSM for the multicycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, one micro-step
// per clock, and drives every enable and mux select of the datapath.
// Ports:
//   clk        in  1  clock, rising edge
//   reset      in  1  asynchronous active-high, forces FETCH
//   op         in  6  instr[31:26]
//   funct      in  6  instr[5:0]
//   zero       in  1  ALU zero flag (current cycle)
//   iord       out 1  memory address: 0 = PC, 1 = ALUOut
//   memwrite   out 1  memory write strobe
//   irwrite    out 1  instruction register load
//   regdst     out 1  write register: 0 = rt, 1 = rd
//   memtoreg   out 1  writeback data: 0 = ALUOut, 1 = Data
//   regwrite   out 1  register file write enable
//   alusrca    out 1  ALU A: 0 = PC, 1 = A
//   alusrcb    out 2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   pcsrc      out 2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump
//   alucontrol out 3  ALU operation code
//   pcen       out 1  PC enable = pcwrite | (branch & zero)
//   state      out 4  current state encoding (debug)
// ----------------------------------------------------------------------------
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic [3:0] state
);

    // Plain 4-bit register rather than the enum type so that the unused
    // codes 12-15 are representable and can be steered back to FETCH.
    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= FETCH;
        else
            state_reg <= state_next;
    end

    // Next-state logic. op is only looked at in DECODE and MEMADR, where the
    // instruction register is guaranteed stable.
    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMPEX;
                    default:      state_next = FETCH;  // unsupported: no-op
                endcase
            end
            MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next = MEMWB;
            RTYPEEX: state_next = ALUWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;  // terminal states and illegal codes
        endcase
    end

    // Moore output decode; everything not named for a state stays 0.
    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        case (state_reg)
            FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            DECODE:  alusrcb = 2'b11;  // precompute branch target
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB:  regwrite = 1'b1;
            JUMPEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Branch decision is combinational on the current zero flag.
    assign pcen  = pcwrite | (branch & zero);
    assign state = state_reg;

endmodule
